// File: rtl/coef_pair_loader.sv
// -----------------------------------------------------------------------------
// coef_pair_loader
//
// Accepts a stream of unsigned 16-bit coefficients over a valid/ready
// handshake, reduces each one into [0, Q), and writes them pairwise
// (even/odd address) into the NTT wrapper's dual-port load interface.
// One polynomial of N coefficients is loaded per load_start request.
//
// Ports:
//   clk                      - single clock, rising edge
//   rst                      - asynchronous reset, active low
//   load_start               - single-cycle request to begin a load
//   abort                    - synchronous cancel of the load in progress
//   in_valid/in_ready/in_data- upstream coefficient handshake
//   we                       - one-cycle write strobe per coefficient pair
//   address_ina/address_inb  - even/odd write addresses (2k, 2k+1)
//   data_ina/data_inb        - even/odd reduced coefficients
//   busy                     - load in progress (same as in_ready)
//   load_done                - all N coefficients written
//   range_err                - sticky: a coefficient >= 2Q arrived this load
// -----------------------------------------------------------------------------
module coef_pair_loader #(
    parameter int N = 256,
    parameter int Q = 3329
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        we,
    output logic [7:0]  address_ina,
    output logic [7:0]  address_inb,
    output logic [15:0] data_ina,
    output logic [15:0] data_inb,
    output logic        busy,
    output logic        load_done,
    output logic        range_err
);

    typedef enum logic [1:0] {
        IDLE,
        EVEN,
        ODD,
        DONE
    } state_t;

    localparam logic [6:0]  K_LAST = 7'(N / 2 - 1);
    localparam logic [16:0] Q_EXT  = 17'(Q);
    localparam logic [16:0] Q2_EXT = 17'(2 * Q);

    state_t      state;
    state_t      state_next;
    logic [6:0]  k;
    logic [15:0] held;
    logic        xfer;
    logic        start_ok;
    logic        last_pair;
    logic [16:0] x_ext;
    logic [15:0] x_red;
    logic        x_oor;

    assign in_ready  = (state == EVEN) || (state == ODD);
    assign busy      = in_ready;
    assign xfer      = in_valid && in_ready;
    assign start_ok  = load_start && ((state == IDLE) || (state == DONE));
    assign last_pair = (k == K_LAST);

    // Single conditional subtraction is enough for inputs below 2Q; anything
    // larger is treated as corrupt input, written as 0 and flagged.
    always_comb begin
        x_ext = {1'b0, in_data};
        x_red = in_data;
        x_oor = 1'b0;
        if (x_ext >= Q2_EXT) begin
            x_red = 16'd0;
            x_oor = 1'b1;
        end else if (x_ext >= Q_EXT) begin
            x_red = 16'(x_ext - Q_EXT);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort takes priority over everything, including a same-cycle
    // load_start or a pending ODD transfer.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (load_start) begin
                        state_next = EVEN;
                    end
                end
                EVEN: begin
                    if (xfer) begin
                        state_next = ODD;
                    end
                end
                ODD: begin
                    if (xfer) begin
                        state_next = last_pair ? DONE : EVEN;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // The even coefficient waits in 'held' until its odd partner arrives;
    // the pair is then written as a registered beat on the following cycle,
    // which is why load_done is raised on the same edge as the final we.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k           <= '0;
            held        <= '0;
            we          <= 1'b0;
            address_ina <= '0;
            address_inb <= '0;
            data_ina    <= '0;
            data_inb    <= '0;
            load_done   <= 1'b0;
            range_err   <= 1'b0;
        end else begin
            we <= 1'b0;
            if (abort) begin
                load_done <= 1'b0;
            end else if (start_ok) begin
                k         <= '0;
                load_done <= 1'b0;
                range_err <= 1'b0;
            end else if (xfer) begin
                if (x_oor) begin
                    range_err <= 1'b1;
                end
                if (state == EVEN) begin
                    held <= x_red;
                end else begin
                    we          <= 1'b1;
                    address_ina <= {k, 1'b0};
                    address_inb <= {k, 1'b1};
                    data_ina    <= held;
                    data_inb    <= x_red;
                    k           <= k + 7'd1;
                    if (last_pair) begin
                        load_done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/coef_pair_loader.md
COEF_PAIR_LOADER -- requirements
Module: coef_pair_loader

Interface
REQ-001 SHALL have parameter N, default 256, giving coefficients per polynomial (even, at most 256).
REQ-002 SHALL have parameter Q, default 3329, giving the Kyber modulus used for input reduction.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port load_start, input, 1, single-cycle request to begin loading one polynomial.
REQ-006 SHALL have port abort, input, 1, synchronous cancel of the load in progress.
REQ-007 SHALL have port in_valid, input, 1, upstream coefficient valid.
REQ-008 SHALL have port in_ready, output, 1, loader accepts in_data this cycle.
REQ-009 SHALL have port in_data, input, 16, unsigned coefficient; transfer occurs when in_valid and in_ready are both 1.
REQ-010 SHALL have port we, output, 1, one-cycle write strobe to the NTT wrapper's dual-port load interface.
REQ-011 SHALL have ports address_ina and address_inb, output, 8 each, even and odd write addresses.
REQ-012 SHALL have ports data_ina and data_inb, output, 16 each, even and odd reduced coefficients.
REQ-013 SHALL have port busy, output, 1, load in progress.
REQ-014 SHALL have port load_done, output, 1, all N coefficients written.
REQ-015 SHALL have port range_err, output, 1, sticky flag for an out-of-range coefficient in the current load.

Function
REQ-016 SHALL implement states IDLE, EVEN, ODD and DONE.
REQ-017 SHALL, in IDLE or DONE, move to EVEN on load_start=1, clearing pair index k, range_err and load_done.
REQ-018 SHALL ignore load_start while in EVEN or ODD.
REQ-019 SHALL drive in_ready=1 exactly in EVEN and ODD; busy SHALL equal in_ready.
REQ-020 SHALL, in EVEN, on a transfer, store the reduced coefficient in a holding register and move to ODD.
REQ-021 SHALL, in ODD, on a transfer, drive a write beat on the next cycle: we=1, address_ina=2k, address_inb=2k+1, data_ina=held value, data_inb=reduced value.
REQ-022 SHALL, after the ODD transfer, increment k and move to EVEN, or to DONE if k was N/2-1.
REQ-023 SHALL hold we at 1 for exactly one cycle per beat; address and data outputs SHALL hold their last values while we=0.
REQ-024 SHALL stall in EVEN or ODD without side effects while in_valid=0.
REQ-025 SHALL reduce coefficient x as follows: x<Q gives x; Q<=x<2Q gives x-Q; x>=2Q gives 0 and sets range_err.
REQ-026 SHALL assert load_done in the same cycle as the final beat's we and hold it in DONE until the next load_start or abort.
REQ-027 SHALL, on abort=1 in any state, go to IDLE next cycle, discard any held coefficient, emit no beat and clear load_done.
REQ-028 SHALL let abort win over a same-cycle ODD transfer (no beat) and over a same-cycle load_start (IDLE).
REQ-029 SHALL sustain one coefficient per cycle, i.e. N/2 beats in N cycles of continuous in_valid.

Reset
REQ-030 SHALL, while rst=0, immediately force state IDLE, k=0, and in_ready, we, address_ina, address_inb, data_ina, data_inb, busy, load_done and range_err all to 0.
REQ-031 SHALL treat reset mid-load as a full abort; the first load after reset release SHALL start at address 0.

Verification
REQ-032 Reset: rst=0 with random inputs -> all outputs 0 and no we.
REQ-033 Continuous stream 0..255 with in_valid=1 -> 128 we pulses on alternate cycles; beat k has addresses 2k/2k+1 and data 2k/2k+1; load_done rises with beat 127; range_err=0.
REQ-034 Reduction: in_data 3329, 3330, 6657, 6658 -> written values 0, 1, 3328, 0; range_err=1 after 6658 is accepted.
REQ-035 in_valid toggling pseudo-randomly -> identical writes to REQ-033, exactly 128 we pulses, no duplicates.
REQ-036 abort after the third coefficient -> only beat 0 is emitted; the next load_start writes address_ina=0 with the first new coefficient.
REQ-037 rst pulsed low at beat 40, then load_start -> outputs 0 during reset; the reload completes 128 beats from address 0.
